// File: rtl/bfly_sel_pkg.sv
// Shared types and defaults for the butterfly add/sub select controller.
package bfly_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2
    } bfly_sel_state_t;

    localparam int DEF_HALF_LEN         = 8;
    localparam int DEF_BLOCKS_PER_FRAME = 1;

    // Bit width for a count of v values, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bfly_phase_cnt.sv
// Phase counter for one butterfly block: counts 0..2*HALF_LEN-1 and wraps,
// flagging the last ADD cycle and the last SUB cycle.
module bfly_phase_cnt #(
    parameter int HALF_LEN = 8,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tc_half,
    output logic          tc_full
);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_LEN - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(2 * HALF_LEN - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == FULL_LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign cnt     = cnt_reg;
    assign tc_half = (cnt_reg == HALF_LAST);
    assign tc_full = (cnt_reg == FULL_LAST);

endmodule

// File: rtl/bfly_sel_ctrl.sv
// Butterfly add/sub mux-select controller with a one-deep start queue and flush.
// Optional overrun pulse output enabled by defining BFLY_SEL_OVR_EN.
module bfly_sel_ctrl
    import bfly_sel_pkg::*;
#(
    parameter int   HALF_LEN         = DEF_HALF_LEN,
    parameter int   BLOCKS_PER_FRAME = DEF_BLOCKS_PER_FRAME,
    parameter logic SUB_SEL_VAL      = 1'b1,
    localparam int  CW               = clog2_min1(2 * HALF_LEN),
    localparam int  BW               = clog2_min1(BLOCKS_PER_FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alert_start,
    input  logic          flush,
    output logic          mux_sel,
    output logic          active,
    output logic [BW-1:0] blk_idx,
    output logic [CW-1:0] phase_cnt,
    output logic          block_done,
    output logic          frame_done
`ifdef BFLY_SEL_OVR_EN
    ,
    output logic          ovr
`endif
);

    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCKS_PER_FRAME - 1);

    bfly_sel_state_t state_reg, state_next;
    logic [BW-1:0]   blk_reg, blk_next;
    logic            pending_reg, pending_next;
    logic            mux_reg, mux_next;
    logic            active_reg, active_next;
    logic            drop_next;
    logic            tc_half, tc_full;
    logic [CW-1:0]   cnt;

    bfly_phase_cnt #(
        .HALF_LEN (HALF_LEN),
        .CW       (CW)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (state_reg != IDLE),
        .clr     (flush),
        .cnt     (cnt),
        .tc_half (tc_half),
        .tc_full (tc_full)
    );

    assign block_done = (state_reg == SUB) && tc_full;
    assign frame_done = block_done && (blk_reg == BLK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            blk_reg     <= '0;
            pending_reg <= 1'b0;
            mux_reg     <= ~SUB_SEL_VAL;
            active_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            blk_reg     <= blk_next;
            pending_reg <= pending_next;
            mux_reg     <= mux_next;
            active_reg  <= active_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        blk_next     = blk_reg;
        pending_next = pending_reg;
        drop_next    = 1'b0;

        if (flush) begin
            state_next   = IDLE;
            blk_next     = '0;
            pending_next = 1'b0;
        end else begin
            // Requests arriving mid-frame are queued once; a second one is lost.
            if ((state_reg != IDLE) && alert_start && !frame_done) begin
                if (pending_reg) begin
                    drop_next = 1'b1;
                end else begin
                    pending_next = 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (alert_start) begin
                        state_next = ADD;
                        blk_next   = '0;
                    end
                end
                ADD: begin
                    if (tc_half) begin
                        state_next = SUB;
                    end
                end
                SUB: begin
                    if (tc_full) begin
                        if (blk_reg != BLK_LAST) begin
                            state_next = ADD;
                            blk_next   = blk_reg + BW'(1);
                        end else if (pending_reg || alert_start) begin
                            // Back-to-back frame: the queued request is consumed.
                            state_next   = ADD;
                            blk_next     = '0;
                            pending_next = 1'b0;
                            drop_next    = pending_reg && alert_start;
                        end else begin
                            state_next = IDLE;
                            blk_next   = '0;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    blk_next   = '0;
                end
            endcase
        end

        mux_next    = (state_next == SUB) ? SUB_SEL_VAL : ~SUB_SEL_VAL;
        active_next = (state_next != IDLE);
    end

    assign mux_sel   = mux_reg;
    assign active    = active_reg;
    assign blk_idx   = blk_reg;
    assign phase_cnt = cnt;

`ifdef BFLY_SEL_OVR_EN
    logic ovr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_reg <= 1'b0;
        end else begin
            ovr_reg <= drop_next;
        end
    end

    assign ovr = ovr_reg;
`else
    logic unused_drop;
    assign unused_drop = drop_next;
`endif

endmodule

// File: tb/tb_bfly_sel_ctrl.sv
// Bench for bfly_sel_ctrl: three configurations (8/2, 1/1, 8/1) share stimulus
// and are compared every cycle against a frame-position reference model.
module tb_bfly_sel_ctrl;

    localparam logic ADDV = 1'b0;
    localparam logic SUBV = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alert = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    logic       mux0, act0, bd0, fd0;
    logic [0:0] blk0;
    logic [3:0] ph0;
    logic       mux1, act1, bd1, fd1;
    logic [0:0] blk1;
    logic [0:0] ph1;
    logic       mux2, act2, bd2, fd2;
    logic [0:0] blk2;
    logic [3:0] ph2;
`ifdef BFLY_SEL_OVR_EN
    logic       ovr0, ovr1, ovr2;
`endif

    bfly_sel_ctrl #(.HALF_LEN(8), .BLOCKS_PER_FRAME(2), .SUB_SEL_VAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .alert_start(alert), .flush(flush),
        .mux_sel(mux0), .active(act0), .blk_idx(blk0), .phase_cnt(ph0),
        .block_done(bd0), .frame_done(fd0)
`ifdef BFLY_SEL_OVR_EN
        , .ovr(ovr0)
`endif
    );

    bfly_sel_ctrl #(.HALF_LEN(1), .BLOCKS_PER_FRAME(1), .SUB_SEL_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .alert_start(alert), .flush(flush),
        .mux_sel(mux1), .active(act1), .blk_idx(blk1), .phase_cnt(ph1),
        .block_done(bd1), .frame_done(fd1)
`ifdef BFLY_SEL_OVR_EN
        , .ovr(ovr1)
`endif
    );

    bfly_sel_ctrl #(.HALF_LEN(8), .BLOCKS_PER_FRAME(1), .SUB_SEL_VAL(1'b1)) dut2 (
        .clk(clk), .rst(rst), .alert_start(alert), .flush(flush),
        .mux_sel(mux2), .active(act2), .blk_idx(blk2), .phase_cnt(ph2),
        .block_done(bd2), .frame_done(fd2)
`ifdef BFLY_SEL_OVR_EN
        , .ovr(ovr2)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input int d, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %0d want %0d", name, d, $time, got, want);
        end
    endtask

    // Reference model: position within the frame (-1 = idle) plus queue flag.
    int mh [3] = '{8, 1, 8};
    int mb [3] = '{2, 1, 1};
    int m_pos [3];
    bit m_pend [3];
    bit m_ovr [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_pos[d]  = -1;
            m_pend[d] = 1'b0;
            m_ovr[d]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit a, input bit f, input bit r);
        int last;
        for (int d = 0; d < 3; d++) begin
            last     = 2 * mh[d] * mb[d] - 1;
            m_ovr[d] = 1'b0;
            if (r || f) begin
                m_pos[d]  = -1;
                m_pend[d] = 1'b0;
            end else if (m_pos[d] < 0) begin
                if (a) m_pos[d] = 0;
            end else if (m_pos[d] == last) begin
                if (m_pend[d] || a) begin
                    m_ovr[d]  = m_pend[d] && a;
                    m_pend[d] = 1'b0;
                    m_pos[d]  = 0;
                end else begin
                    m_pos[d] = -1;
                end
            end else begin
                m_pos[d] = m_pos[d] + 1;
                if (a) begin
                    if (m_pend[d]) m_ovr[d] = 1'b1;
                    else m_pend[d] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_all();
        int g_act, g_mux, g_blk, g_ph, g_bd, g_fd, g_ovr;
        int e_act, e_mux, e_blk, e_ph, e_bd, e_fd, p, len;
        for (int d = 0; d < 3; d++) begin
            g_ovr = 0;
            case (d)
                0: begin
                    g_act = int'(act0); g_mux = int'(mux0); g_blk = int'(blk0);
                    g_ph = int'(ph0); g_bd = int'(bd0); g_fd = int'(fd0);
`ifdef BFLY_SEL_OVR_EN
                    g_ovr = int'(ovr0);
`endif
                end
                1: begin
                    g_act = int'(act1); g_mux = int'(mux1); g_blk = int'(blk1);
                    g_ph = int'(ph1); g_bd = int'(bd1); g_fd = int'(fd1);
`ifdef BFLY_SEL_OVR_EN
                    g_ovr = int'(ovr1);
`endif
                end
                default: begin
                    g_act = int'(act2); g_mux = int'(mux2); g_blk = int'(blk2);
                    g_ph = int'(ph2); g_bd = int'(bd2); g_fd = int'(fd2);
`ifdef BFLY_SEL_OVR_EN
                    g_ovr = int'(ovr2);
`endif
                end
            endcase
            p     = m_pos[d];
            len   = 2 * mh[d];
            e_act = (p >= 0) ? 1 : 0;
            e_ph  = (p >= 0) ? p % len : 0;
            e_blk = (p >= 0) ? p / len : 0;
            e_mux = (p >= 0 && e_ph >= mh[d]) ? int'(SUBV) : int'(ADDV);
            e_bd  = (p >= 0 && e_ph == len - 1) ? 1 : 0;
            e_fd  = (p == len * mb[d] - 1) ? 1 : 0;
            cmp("m_active", d, g_act, e_act);
            cmp("m_mux_sel", d, g_mux, e_mux);
            cmp("m_blk_idx", d, g_blk, e_blk);
            cmp("m_phase_cnt", d, g_ph, e_ph);
            cmp("m_block_done", d, g_bd, e_bd);
            cmp("m_frame_done", d, g_fd, e_fd);
`ifdef BFLY_SEL_OVR_EN
            cmp("m_ovr", d, g_ovr, int'(m_ovr[d]));
`else
            cmp("m_ovr_absent", d, g_ovr, 0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(alert, flush, rst);
        #1;
        check_all();
    endtask

    task automatic settle();
        alert = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 40; i++) step();
    endtask

    // Start a frame, inject alert/flush at given active cycles, count active cycles.
    task automatic run_frame(input int al_a, input int al_b, input int fl_c,
                             input int ovr_c, output int n);
        int done;
        done  = 0;
        alert = 1'b1;
        step();
        alert = 1'b0;
        n = act0 ? 1 : 0;
        for (int c = 1; c < 200; c++) begin
            alert = (c == al_a) || (c == al_b);
            flush = (c == fl_c);
            step();
            alert = 1'b0;
            flush = 1'b0;
`ifdef BFLY_SEL_OVR_EN
            if (c == ovr_c) cmp("ovr_pulse", 0, int'(ovr0), 1);
`endif
            if (!act0) begin
                done = 1;
                break;
            end
            n++;
        end
        if (done == 0) cmp("frame_timeout", 0, 1, 0);
    endtask

    typedef struct {
        int   cyc;
        logic act;
        logic mux;
        int   blk;
        int   ph;
        logic bd;
        logic fd;
    } vec_t;

    vec_t vt [9];

    initial begin
        int n, vi;

        vt[0] = '{1,  1'b1, ADDV, 0, 0,  1'b0, 1'b0};
        vt[1] = '{8,  1'b1, ADDV, 0, 7,  1'b0, 1'b0};
        vt[2] = '{9,  1'b1, SUBV, 0, 8,  1'b0, 1'b0};
        vt[3] = '{16, 1'b1, SUBV, 0, 15, 1'b1, 1'b0};
        vt[4] = '{17, 1'b1, ADDV, 1, 0,  1'b0, 1'b0};
        vt[5] = '{25, 1'b1, SUBV, 1, 8,  1'b0, 1'b0};
        vt[6] = '{32, 1'b1, SUBV, 1, 15, 1'b1, 1'b1};
        vt[7] = '{33, 1'b0, ADDV, 0, 0,  1'b0, 1'b0};
        vt[8] = '{34, 1'b0, ADDV, 0, 0,  1'b0, 1'b0};

        model_reset();
        #1;
        cmp("rst_active", 0, int'(act0), 0);
        cmp("rst_mux_sel", 0, int'(mux0), int'(ADDV));
        cmp("rst_phase", 0, int'(ph0), 0);
        cmp("rst_frame_done", 0, int'(fd0), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single frame against the table.
        vi = 0;
        alert = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            alert = 1'b0;
            if (vi < 9 && vt[vi].cyc == k) begin
                cmp("tbl_active", k, int'(act0), int'(vt[vi].act));
                cmp("tbl_mux_sel", k, int'(mux0), int'(vt[vi].mux));
                cmp("tbl_blk_idx", k, int'(blk0), vt[vi].blk);
                cmp("tbl_phase", k, int'(ph0), vt[vi].ph);
                cmp("tbl_block_done", k, int'(bd0), int'(vt[vi].bd));
                cmp("tbl_frame_done", k, int'(fd0), int'(vt[vi].fd));
                vi++;
            end
        end
        settle();

        run_frame(32, -1, -1, -1, n);
        cmp("b2b_active_cycles", 0, n, 64);
        settle();

        run_frame(5, 9, -1, 9, n);
        cmp("queue_active_cycles", 0, n, 64);
        settle();

        run_frame(5, 12, 12, -1, n);
        cmp("flush_active_cycles", 0, n, 12);
        cmp("flush_mux_sel", 0, int'(mux0), int'(ADDV));
        cmp("flush_phase", 0, int'(ph0), 0);
        settle();
        cmp("flush_no_restart", 0, int'(act0), 0);

        // Asynchronous reset in the middle of a SUB phase.
        alert = 1'b1;
        step();
        alert = 1'b0;
        for (int i = 0; i < 9; i++) step();
        #3;
        rst = 1'b1;
        #1;
        cmp("async_active", 0, int'(act0), 0);
        cmp("async_mux_sel", 0, int'(mux0), int'(ADDV));
        cmp("async_phase", 0, int'(ph0), 0);
        cmp("async_blk_idx", 0, int'(blk0), 0);
        step();
        rst = 1'b0;
        step();
        run_frame(-1, -1, -1, -1, n);
        cmp("post_rst_active_cycles", 0, n, 32);
        settle();

        // HALF_LEN=1 corner: sustained requests make mux_sel toggle every cycle.
        alert = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            cmp("h1_mux_sel", 1, int'(mux1), (i % 2 == 1) ? int'(SUBV) : int'(ADDV));
            cmp("h1_block_done", 1, int'(bd1), i % 2);
            cmp("h1_frame_done", 1, int'(fd1), i % 2);
        end
        alert = 1'b0;
        settle();

        // Randomised traffic including flush and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            alert = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
